serial_addsub16: RTL

Multi-cycle signed 16-bit add/subtract unit that processes one 4-bit nibble per clock through a single ripple slice, LSB nibble first, carrying between cycles. It sits directly downstream of the 4-bit add/sub datapath work and widens it to the processor's 16-bit word. It offers a valid/ready handshake on both sides, so an ALU sequencer can issue operands and consume the sum and flags (overflow, zero, negative) when ready.

---
 rtl/serial_addsub16_pkg.sv | 16 +
 rtl/serial_addsub16_if.sv | 28 ++
 rtl/serial_addsub16_slice.sv | 24 ++
 rtl/serial_addsub16.sv | 95 +++++++++
 4 files changed

// File: rtl/serial_addsub16_pkg.sv
// Shared types and constants for the nibble-serial 16-bit add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIB_W = 4;

    function automatic int nibbles(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/serial_addsub16_if.sv
// Operand/result handshake bundle between an ALU sequencer and serial_addsub16.
interface serial_addsub16_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovfl, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovfl, zero, neg
    );

endinterface

// File: rtl/serial_addsub16_slice.sv
// Combinational 4-bit ripple slice; b is already inverted for subtraction.
module nibble_addsub_slice
    import serial_addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [3:0] low;
    logic [1:0] top;

    // Split at bit 3 so the carry into the MSB is visible for overflow.
    assign low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    assign top  = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};

    assign s    = {top[0], low[2:0]};
    assign cout = top[1];
    assign c3   = low[3];

endmodule

// File: rtl/serial_addsub16.sv
// Signed add/subtract that walks one nibble per clock through a single slice.
module serial_addsub16
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    serial_addsub16_if.slave  bus
);

    localparam int NIBS  = nibbles(WIDTH);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovfl_q;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_s;
    logic             nib_cout;
    logic             nib_c3;

    assign nib_a = a_q[idx*NIB_W +: NIB_W];
    assign nib_b = b_q[idx*NIB_W +: NIB_W];

    nibble_addsub_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = RUN;
            RUN:     if (idx == LAST)  state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is folded in at capture: invert b and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.sub;
                        idx     <= '0;
                        sum_q   <= '0;
                        ovfl_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx*NIB_W +: NIB_W] <= nib_s;
                    carry_q                   <= nib_cout;
                    if (idx == LAST) ovfl_q <= nib_c3 ^ nib_cout;
                    else             idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.ovfl      = ovfl_q;
    assign bus.zero      = ~|sum_q;
    assign bus.neg       = sum_q[WIDTH-1];

endmodule
